mem_port_arb4: RTL

- Round-robin arbiter that shares one 32-bit memory/bus port between four requesters, such as IF, LSU, debug and DMA.
- Its registered sel_o drives the sel_i of the 4:1 32-bit data/address muxes in front of the port.
- A grant is held stable until the port acknowledges.
- A watchdog releases a stuck grant and flags an error.

---
 rtl/mem_port_arb4.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_port_arb4.sv
// Round-robin arbiter sharing one memory port between four requesters.
// Holds each grant until mem_ack_i; a watchdog drops a stuck grant and pulses err_o.
module mem_port_arb4 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic       mem_ack_i,
  output logic [3:0] grant_o,
  output logic [1:0] sel_o,
  output logic       mem_req_o,
  output logic       err_o,
  output logic [1:0] err_id_o,
  output logic       state_o
);

  // Handshake: mem_req_o is the port's valid and stays high, with grant_o and
  // sel_o frozen, until mem_ack_i is seen at a rising edge; mem_ack_i is
  // ignored while mem_req_o is low.

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [1:0]    last_q;
  logic [1:0]    base;
  logic          pick_hit;
  logic [1:0]    pick_idx;

  // Searches last+1 .. last+4, so the previous winner is considered last.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
    logic [1:0] idx;
    logic       hit;
    logic [1:0] res;
    hit = 1'b0;
    res = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        res = idx;
      end
    end
    return {hit, res};
  endfunction

  // On an ack the just-served index becomes "last" in the same edge.
  always_comb begin
    base = (state_q == GRANT) ? sel_o : last_q;
    {pick_hit, pick_idx} = rr_pick(base, req_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      last_q    <= 2'd3;
      grant_o   <= 4'b0000;
      sel_o     <= 2'd0;
      mem_req_o <= 1'b0;
      err_o     <= 1'b0;
      err_id_o  <= 2'd0;
    end else begin
      err_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_hit) begin
            state_q   <= GRANT;
            count_q   <= '0;
            grant_o   <= 4'b0001 << pick_idx;
            sel_o     <= pick_idx;
            mem_req_o <= 1'b1;
          end
        end
        GRANT: begin
          if (mem_ack_i) begin
            last_q  <= sel_o;
            count_q <= '0;
            if (pick_hit) begin
              grant_o <= 4'b0001 << pick_idx;
              sel_o   <= pick_idx;
            end else begin
              state_q   <= IDLE;
              grant_o   <= 4'b0000;
              mem_req_o <= 1'b0;
            end
          end else if (count_q == CNT_LAST) begin
            state_q   <= IDLE;
            count_q   <= '0;
            last_q    <= sel_o;
            grant_o   <= 4'b0000;
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
            err_id_o  <= sel_o;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o = state_q;

endmodule
